mult8_seq_ctrl: RTL and testbench
=================================

# mult8_seq_ctrl

Sequencing controller that computes an unsigned 8x8 product by time-multiplexing one shared 4x4 combinational array multiplier over four partial-product cycles. It accepts operand pairs on a valid/ready handshake, drives the external multiplier's operand nibbles, accumulates the shifted 8-bit partial products into a 16-bit result, and presents the result on a valid/ready output handshake. It sits between the tile's I/O wrapper and the 4x4 array multiplier.

## Interface
- ZERO_BYPASS, default 1: when 1, an operand pair with a == 0 or b == 0 skips the multiplier and completes with product 0.
- clk  input  1  single clock; all state updates on the rising edge.
- rst_n  input  1  reset, asynchronous and active-low.
- in_valid  input  1  operand pair valid.
- in_ready  output  1  controller can accept; equals (state == IDLE).
- a  input  8  multiplicand, unsigned.
- b  input  8  multiplier, unsigned.
- out_valid  output  1  product valid; equals (state == DONE).
- out_ready  input  1  consumer accepts product.
- product  output  16  registered result a*b.
- mul_m  output  4  operand nibble to the shared 4x4 multiplier (m input).
- mul_q  output  4  operand nibble to the shared 4x4 multiplier (q input).
- mul_p  input  8  8-bit product returned combinationally by the shared multiplier.
- busy  output  1  high in PP0..PP3.

## Operation
- States: IDLE, PP0, PP1, PP2, PP3, DONE. Register state, operand latches a_r/b_r (8 bits each), accumulator acc (16 bits). product = acc.
- IDLE: in_ready = 1. On in_valid & in_ready: latch a_r = a, b_r = b, clear acc to 0. Next state: DONE if ZERO_BYPASS && (a == 0 || b == 0), else PP0.
- Nibble selection, combinational from state and latches: PP0 m = a_r[3:0], q = b_r[3:0]; PP1 m = a_r[7:4], q = b_r[3:0]; PP2 m = a_r[3:0], q = b_r[7:4]; PP3 m = a_r[7:4], q = b_r[7:4]. In IDLE and DONE, mul_m = mul_q = 0.
- Accumulation at the end of each PP state: acc += zero-extended mul_p shifted left by 0 (PP0), 4 (PP1), 4 (PP2), 8 (PP3). PPn advances unconditionally to PPn+1; PP3 advances to DONE.
- Width: the maximum result is 255*255 = 0xFE01, which fits in 16 bits. No overflow or saturation logic is required.
- DONE: out_valid = 1. product is held stable until out_valid & out_ready, then the state returns to IDLE. acc is not cleared on exit; product keeps the last result until the next accept.
- in_valid is ignored whenever in_ready = 0. a and b may change freely after the accept edge.
- mul_p is sampled only in PP0..PP3. Its value in other states has no effect.

## Timing
- Reset (asynchronous, takes effect immediately): state = IDLE, in_ready = 1, out_valid = 0, busy = 0, product = 0x0000, mul_m = mul_q = 0, a_r = b_r = 0.
- Reset mid-operation: any in-flight operation is discarded and no out_valid is issued for it. After release, the next operation is fully correct.
- Latency, normal path: an accept at edge T gives out_valid = 1 in the cycle after edge T+4 (four PP cycles).
- Latency, zero bypass: out_valid = 1 in the cycle after edge T, with product = 0.
- Throughput: one result per 6 cycles when out_ready is held high (accept, 4 PP cycles, DONE). in_ready returns to 1 in the cycle after the output handshake. There is no accept during DONE, even if an output handshake occurs in the same cycle.
- The path from mul_p through the adder to acc is single-cycle. The external multiplier plus the 16-bit adder must meet one clock period.
- All outputs except mul_m/mul_q are registered or decoded from state only. mul_m/mul_q are muxed from registers and have no input-to-output combinational path.

## Test plan
- Reset: hold rst_n = 0 mid-cycle -> in_ready = 1, out_valid = 0, busy = 0, product = 0x0000, mul_m = mul_q = 0, all asynchronous (no edge needed).
- a = 0x12, b = 0x34 -> mul_m/mul_q sequence 2/4, 1/4, 2/3, 1/3 and mul_p 8, 4, 6, 3; out_valid 5 cycles after accept with product = 0x03A8.
- a = 0xFF, b = 0xFF -> all four nibble pairs F/F with mul_p = 0xE1; product = 0xFE01, which is the maximum and must not overflow.
- Zero bypass: a = 0x00, b = 0x5A -> with ZERO_BYPASS = 1, out_valid the next cycle, product = 0, busy never asserted. With ZERO_BYPASS = 0, the same stimulus gives out_valid after 5 cycles, product = 0.
- Backpressure: out_ready = 0 for 3 cycles in DONE with in_valid held high and a/b toggling -> product, out_valid = 1, and in_ready = 0 all stable. Then out_ready = 1 -> IDLE next cycle, and the following accept captures the current a/b.
- Reset in PP2 of a = 0xAB, b = 0xCD -> no out_valid, outputs at reset values. Then a = 0x07, b = 0x09 -> product = 0x003F.

Source files
------------

// File: rtl/mult8_seq_ctrl_if.sv
`default_nettype none
// ============================================================================
//  Module   : mult8_seq_ctrl_if
//  Brief    : Operand/result handshakes and shared 4x4 multiplier port bundle.
//  Revision : 1.0
// ============================================================================
interface mult8_seq_ctrl_if;
    logic        in_valid;
    logic        in_ready;
    logic [7:0]  a;
    logic [7:0]  b;
    logic        out_valid;
    logic        out_ready;
    logic [15:0] product;
    logic [3:0]  mul_m;
    logic [3:0]  mul_q;
    logic [7:0]  mul_p;
    logic        busy;

    // slave: the controller; master: wrapper + external multiplier side
    modport slave (
        input  in_valid, a, b, out_ready, mul_p,
        output in_ready, out_valid, product, mul_m, mul_q, busy
    );

    modport master (
        output in_valid, a, b, out_ready, mul_p,
        input  in_ready, out_valid, product, mul_m, mul_q, busy
    );
endinterface
`default_nettype wire

// File: rtl/mult8_seq_ctrl.sv
`default_nettype none
// ============================================================================
//  Module   : mult8_seq_ctrl
//  Brief    : 8x8 unsigned multiply sequenced over four passes of a shared
//             4x4 array multiplier, with valid/ready operand/result ports.
//  Revision : 1.0
// ============================================================================
module mult8_seq_ctrl #(
    parameter bit ZERO_BYPASS = 1'b1
) (
    input  wire logic        clk,
    input  wire logic        rst_n,
    mult8_seq_ctrl_if.slave  bus
);

    typedef enum logic [2:0] {
        S_IDLE = 3'd0,
        S_PP0  = 3'd1,
        S_PP1  = 3'd2,
        S_PP2  = 3'd3,
        S_PP3  = 3'd4,
        S_DONE = 3'd5
    } state_t;

    state_t      r_state;
    state_t      w_state_nxt;
    logic [7:0]  r_a;
    logic [7:0]  r_b;
    logic [15:0] r_acc;

    logic        w_accept;
    logic        w_release;
    logic        w_is_zero;
    logic        w_busy;
    logic [3:0]  w_mul_m;
    logic [3:0]  w_mul_q;
    logic [15:0] w_pp_shifted;

    assign w_accept  = bus.in_valid && (r_state == S_IDLE);
    assign w_release = bus.out_ready && (r_state == S_DONE);
    assign w_is_zero = (bus.a == 8'h00) || (bus.b == 8'h00);
    assign w_busy    = (r_state == S_PP0) || (r_state == S_PP1) ||
                       (r_state == S_PP2) || (r_state == S_PP3);

    // ------------------------------------------------------------------------
    // State register
    // ------------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // ------------------------------------------------------------------------
    // Next-state logic
    // ------------------------------------------------------------------------
    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            S_IDLE: begin
                if (w_accept) begin
                    if (ZERO_BYPASS && w_is_zero) begin
                        w_state_nxt = S_DONE;
                    end else begin
                        w_state_nxt = S_PP0;
                    end
                end
            end
            S_PP0:   w_state_nxt = S_PP1;
            S_PP1:   w_state_nxt = S_PP2;
            S_PP2:   w_state_nxt = S_PP3;
            S_PP3:   w_state_nxt = S_DONE;
            S_DONE: begin
                if (w_release) begin
                    w_state_nxt = S_IDLE;
                end
            end
            default: w_state_nxt = S_IDLE;
        endcase
    end

    // ------------------------------------------------------------------------
    // Nibble selection and partial-product alignment
    // ------------------------------------------------------------------------
    always_comb begin
        w_mul_m      = 4'h0;
        w_mul_q      = 4'h0;
        w_pp_shifted = {8'h00, bus.mul_p};
        case (r_state)
            S_PP0: begin
                w_mul_m = r_a[3:0];
                w_mul_q = r_b[3:0];
            end
            S_PP1: begin
                w_mul_m      = r_a[7:4];
                w_mul_q      = r_b[3:0];
                w_pp_shifted = {4'h0, bus.mul_p, 4'h0};
            end
            S_PP2: begin
                w_mul_m      = r_a[3:0];
                w_mul_q      = r_b[7:4];
                w_pp_shifted = {4'h0, bus.mul_p, 4'h0};
            end
            S_PP3: begin
                w_mul_m      = r_a[7:4];
                w_mul_q      = r_b[7:4];
                w_pp_shifted = {bus.mul_p, 8'h00};
            end
            default: begin
                w_mul_m      = 4'h0;
                w_mul_q      = 4'h0;
                w_pp_shifted = {8'h00, bus.mul_p};
            end
        endcase
    end

    // ------------------------------------------------------------------------
    // Operand latches and accumulator; acc is left untouched on exit so the
    // last product stays visible until the next accept.
    // ------------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_a   <= 8'h00;
            r_b   <= 8'h00;
            r_acc <= 16'h0000;
        end else if (w_accept) begin
            r_a   <= bus.a;
            r_b   <= bus.b;
            r_acc <= 16'h0000;
        end else if (w_busy) begin
            r_acc <= r_acc + w_pp_shifted;
        end
    end

    assign bus.in_ready  = (r_state == S_IDLE);
    assign bus.out_valid = (r_state == S_DONE);
    assign bus.busy      = w_busy;
    assign bus.product   = r_acc;
    assign bus.mul_m     = w_mul_m;
    assign bus.mul_q     = w_mul_q;

endmodule
`default_nettype wire

// File: tb/tb_mult8_seq_ctrl.sv
`default_nettype none
// ============================================================================
//  Module   : tb_mult8_seq_ctrl
//  Brief    : Self-checking bench for mult8_seq_ctrl (both bypass settings).
//  Revision : 1.0
// ============================================================================
module tb_mult8_seq_ctrl;

    logic clk = 1'b0;
    logic rst_n;
    always #5 clk = ~clk;

    mult8_seq_ctrl_if if0 ();
    mult8_seq_ctrl_if if1 ();

    logic        sel;
    logic        r_in_valid;
    logic [7:0]  r_a;
    logic [7:0]  r_b;
    logic        r_out_ready;

    assign if0.in_valid  = r_in_valid & ~sel;
    assign if1.in_valid  = r_in_valid &  sel;
    assign if0.a         = r_a;
    assign if1.a         = r_a;
    assign if0.b         = r_b;
    assign if1.b         = r_b;
    assign if0.out_ready = r_out_ready;
    assign if1.out_ready = r_out_ready;
    // ideal external 4x4 array multiplier
    assign if0.mul_p     = {4'h0, if0.mul_m} * {4'h0, if0.mul_q};
    assign if1.mul_p     = {4'h0, if1.mul_m} * {4'h0, if1.mul_q};

    mult8_seq_ctrl #(.ZERO_BYPASS(1'b1)) u_dut_zb (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (if0.slave)
    );

    mult8_seq_ctrl #(.ZERO_BYPASS(1'b0)) u_dut_nz (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (if1.slave)
    );

    wire         w_in_ready  = sel ? if1.in_ready  : if0.in_ready;
    wire         w_out_valid = sel ? if1.out_valid : if0.out_valid;
    wire         w_busy      = sel ? if1.busy      : if0.busy;
    wire [15:0]  w_product   = sel ? if1.product   : if0.product;
    wire [3:0]   w_mul_m     = sel ? if1.mul_m     : if0.mul_m;
    wire [3:0]   w_mul_q     = sel ? if1.mul_q     : if0.mul_q;

    int n_checks = 0;
    int n_errors = 0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic chk_reset_outputs(input string tag);
        chk({tag, "_in_ready"},  w_in_ready,  1);
        chk({tag, "_out_valid"}, w_out_valid, 0);
        chk({tag, "_busy"},      w_busy,      0);
        chk({tag, "_product"},   w_product,   0);
        chk({tag, "_mul_m"},     w_mul_m,     0);
        chk({tag, "_mul_q"},     w_mul_q,     0);
    endtask

    task automatic wait_ready();
        int n;
        n = 0;
        @(negedge clk);
        while (!w_in_ready && n < 20) begin
            @(negedge clk);
            n++;
        end
        chk("in_ready_wait", w_in_ready, 1);
    endtask

    // One full transaction; hold = cycles of output backpressure in DONE.
    task automatic run_op(input logic [7:0] a, input logic [7:0] b, input int hold);
        int          lat;
        int          n;
        int          k;
        bit          got;
        logic [15:0] exp_p;
        logic [3:0]  em;
        logic [3:0]  eq;

        exp_p = {8'h00, a} * {8'h00, b};
        lat   = (!sel && (a == 8'h00 || b == 8'h00)) ? 1 : 5;

        wait_ready();
        r_in_valid = 1'b1;
        r_a        = a;
        r_b        = b;
        @(posedge clk);
        #1;
        r_in_valid = 1'b0;
        r_a        = 8'($urandom);
        r_b        = 8'($urandom);

        n   = 0;
        got = 1'b0;
        while (!got && n < 20) begin
            @(negedge clk);
            n++;
            if (w_out_valid) begin
                got = 1'b1;
            end else if (n <= 4) begin
                k  = n - 1;
                em = k[0] ? a[7:4] : a[3:0];
                eq = k[1] ? b[7:4] : b[3:0];
                chk("pp_busy",  w_busy,  1);
                chk("pp_mul_m", w_mul_m, em);
                chk("pp_mul_q", w_mul_q, eq);
            end
        end
        chk("latency",       n,           lat);
        chk("product",       w_product,   exp_p);
        chk("done_in_ready", w_in_ready,  0);
        chk("done_busy",     w_busy,      0);

        for (int i = 0; i < hold; i++) begin
            r_in_valid = 1'b1;
            r_a        = 8'($urandom);
            r_b        = 8'($urandom);
            @(negedge clk);
            chk("bp_product",   w_product,   exp_p);
            chk("bp_out_valid", w_out_valid, 1);
            chk("bp_in_ready",  w_in_ready,  0);
        end

        // in_valid stays high across the output handshake: no accept allowed
        r_in_valid  = 1'b1;
        r_out_ready = 1'b1;
        @(posedge clk);
        #1;
        r_out_ready = 1'b0;
        r_in_valid  = 1'b0;
        @(negedge clk);
        chk("post_in_ready",  w_in_ready,  1);
        chk("post_out_valid", w_out_valid, 0);
        chk("post_product",   w_product,   exp_p);
    endtask

    initial begin
        logic [7:0] ra;
        logic [7:0] rb;

        sel         = 1'b0;
        r_in_valid  = 1'b0;
        r_a         = 8'h00;
        r_b         = 8'h00;
        r_out_ready = 1'b0;
        rst_n       = 1'b0;

        #12;
        chk_reset_outputs("rst0_zb");
        sel = 1'b1;
        #1;
        chk_reset_outputs("rst0_nz");
        sel = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;

        run_op(8'h12, 8'h34, 0);
        run_op(8'hFF, 8'hFF, 0);
        run_op(8'h00, 8'h5A, 0);
        sel = 1'b1;
        run_op(8'h00, 8'h5A, 0);
        sel = 1'b0;
        run_op(8'h3C, 8'h91, 3);
        run_op(8'h5E, 8'h77, 0);

        // asynchronous reset while in PP2
        wait_ready();
        r_in_valid = 1'b1;
        r_a        = 8'hAB;
        r_b        = 8'hCD;
        @(posedge clk);
        #1;
        r_in_valid = 1'b0;
        repeat (3) @(negedge clk);
        chk("pp2_busy", w_busy, 1);
        #2;
        rst_n = 1'b0;
        #1;
        chk_reset_outputs("rst_mid");
        @(negedge clk);
        rst_n = 1'b1;
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            chk("rst_no_out_valid", w_out_valid, 0);
        end
        run_op(8'h07, 8'h09, 0);

        for (int i = 0; i < 40; i++) begin
            ra  = ($urandom_range(0, 5) == 0) ? 8'h00 : 8'($urandom);
            rb  = ($urandom_range(0, 5) == 0) ? 8'h00 : 8'($urandom);
            sel = ($urandom_range(0, 3) == 0);
            run_op(ra, rb, $urandom_range(0, 3));
        end
        sel = 1'b0;

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
`default_nettype wire
